// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the barrel shift unit:
//   - DATA_W / SHAMT_BITS : operand width and shift-amount width (log2(DATA_W)+1)
//   - shift_mode_e        : SHIFT_MODE encodings; 3'b101..3'b111 are reserved
//   - is_reserved()       : flags a reserved SHIFT_MODE value
//   - stage_t             : payload carried between pipeline stages
// No ports (package).
// -----------------------------------------------------------------------------
package shift_pkg;

  localparam int DATA_W     = 16;
  localparam int SHAMT_BITS = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {
    MODE_LSR = 3'b000,
    MODE_LSL = 3'b001,
    MODE_ASR = 3'b010,
    MODE_ROR = 3'b011,
    MODE_ROL = 3'b100
  } shift_mode_e;

  // mode is kept as raw bits so reserved encodings can travel with the beat.
  // shamt is the full amount; each stage consumes only its own level bits.
  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic                  carry;
    logic                  sign;
    logic [2:0]            mode;
    logic [SHAMT_BITS-1:0] shamt;
    logic [DATA_W-1:0]     data;
  } stage_t;

  function automatic logic is_reserved(input logic [2:0] mode);
    return (mode > 3'(MODE_ROL));
  endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// -----------------------------------------------------------------------------
// shift_pipe_stage
// A contiguous group of logarithmic mux levels [LVL_LO, LVL_HI) followed by a
// holding register. Level k shifts by 2**k when shamt bit k is set.
// Ports:
//   CLK  in   clock
//   RST  in   synchronous active-high reset, clears the register to zero
//   en   in   register load enable (global advance)
//   d    in   payload entering this stage's mux levels
//   q    out  registered payload
// -----------------------------------------------------------------------------
module shift_pipe_stage
  import shift_pkg::*;
#(
  parameter int LVL_LO = 0,
  parameter int LVL_HI = 1
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   en,
  input  stage_t d,
  output stage_t q
);

  localparam int NLVL = LVL_HI - LVL_LO;

  for (genvar k = 0; k < NLVL; k++) begin : g_lvl
    localparam int LVL = LVL_LO + k;
    localparam int SH  = 1 << LVL;
    // The top level (shift by DATA_W) produces the full-fill results for
    // logical/arithmetic modes; rotates ignore it (amount mod DATA_W).
    localparam bit TOP = (LVL == SHAMT_BITS - 1);
    localparam logic [DATA_W-1:0] FILL = ~({DATA_W{1'b1}} >> SH);

    stage_t cur;
    stage_t nxt;

    if (k == 0) begin : g_src
      assign cur = d;
    end else begin : g_chain
      assign cur = g_lvl[k-1].nxt;
    end

    // Carry is the last bit pushed out by the highest active level; a level
    // that does not shift leaves the carry from earlier levels untouched.
    always_comb begin
      nxt = cur;
      if (cur.shamt[LVL] && !cur.err) begin
        case (cur.mode)
          MODE_LSR: begin
            nxt.data  = cur.data >> SH;
            nxt.carry = cur.data[SH-1];
          end
          MODE_ASR: begin
            nxt.data  = (cur.data >> SH) | (FILL & {DATA_W{cur.sign}});
            nxt.carry = cur.data[SH-1];
          end
          MODE_LSL: begin
            nxt.data  = cur.data << SH;
            nxt.carry = cur.data[DATA_W-SH];
          end
          MODE_ROR: begin
            if (!TOP) begin
              nxt.data  = (cur.data >> SH) | (cur.data << (DATA_W - SH));
              nxt.carry = cur.data[SH-1];
            end
          end
          MODE_ROL: begin
            if (!TOP) begin
              nxt.data  = (cur.data << SH) | (cur.data >> (DATA_W - SH));
              nxt.carry = cur.data[DATA_W-SH];
            end
          end
          default: ;
        endcase
      end
    end
  end

  stage_t comb_out;
  assign comb_out = g_lvl[NLVL-1].nxt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      q <= '0;
    end else if (en) begin
      q <= comb_out;
    end
  end

endmodule

// File: rtl/barrel_shift_unit.sv
// -----------------------------------------------------------------------------
// barrel_shift_unit
// Pipelined multi-bit shifter (LSR, LSL, ASR, ROR, ROL) with valid/ready flow.
// Ports:
//   CLK, RST    clock, synchronous active-high reset
//   A, B        operands; SRC_SEL picks A (0) or B (1)
//   SHIFT_MODE  000 LSR, 001 LSL, 010 ASR, 011 ROR, 100 ROL, others reserved
//   SHAMT       shift amount, 0 .. 2*WIDTH-1
//   In_Valid    input beat valid;  In_Ready  unit accepts the beat
//   SHIFT_OUT   result;            SHIFT_Flag output valid
//   Out_Ready   downstream accepts the output
//   CARRY_OUT   last bit shifted/rotated out
//   ZERO_Flag   SHIFT_OUT == 0
//   MODE_ERR    the beat used a reserved mode (passed through unchanged)
//
// Handshake: an input beat transfers on a rising edge where In_Valid &&
// In_Ready; an output beat transfers on a rising edge where SHIFT_Flag &&
// Out_Ready. The whole pipeline moves together: advance = !SHIFT_Flag ||
// Out_Ready and In_Ready = advance, so a stalled output freezes every stage
// (bubbles included) and holds all outputs stable.
// -----------------------------------------------------------------------------
module barrel_shift_unit
  import shift_pkg::*;
#(
  parameter  int WIDTH       = DATA_W,
  parameter  int PIPE_STAGES = 2,
  localparam int SHAMT_W     = $clog2(WIDTH) + 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               SRC_SEL,
  input  logic [2:0]         SHIFT_MODE,
  input  logic [SHAMT_W-1:0] SHAMT,
  input  logic               In_Valid,
  output logic               In_Ready,
  output logic [WIDTH-1:0]   SHIFT_OUT,
  output logic               SHIFT_Flag,
  input  logic               Out_Ready,
  output logic               CARRY_OUT,
  output logic               ZERO_Flag,
  output logic               MODE_ERR
);

  // The stage payload is sized by the package, so the operand width is set
  // there; WIDTH exists to size the ports and must agree with it.
  if (WIDTH != DATA_W || PIPE_STAGES < 1 || PIPE_STAGES > SHAMT_W) begin : g_bad_params
    $error("barrel_shift_unit: WIDTH must equal shift_pkg::DATA_W and PIPE_STAGES must be 1..log2(WIDTH)+1");
  end

  logic   advance;
  stage_t stg_in;
  stage_t last;

  always_comb begin
    stg_in       = '0;
    stg_in.data  = SRC_SEL ? B : A;
    stg_in.sign  = stg_in.data[WIDTH-1];
    stg_in.shamt = SHAMT;
    stg_in.mode  = SHIFT_MODE;
    stg_in.err   = is_reserved(SHIFT_MODE);
    stg_in.carry = 1'b0;
    stg_in.valid = In_Valid;
  end

  // Mux levels are split as evenly as possible across the stages; the last
  // stage register drives the outputs directly.
  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    stage_t d_s;
    stage_t q_s;

    if (s == 0) begin : g_head
      assign d_s = stg_in;
    end else begin : g_tail
      assign d_s = g_stage[s-1].q_s;
    end

    shift_pipe_stage #(
      .LVL_LO((s * SHAMT_W) / PIPE_STAGES),
      .LVL_HI(((s + 1) * SHAMT_W) / PIPE_STAGES)
    ) u_stage (
      .CLK (CLK),
      .RST (RST),
      .en  (advance),
      .d   (d_s),
      .q   (q_s)
    );
  end

  assign last = g_stage[PIPE_STAGES-1].q_s;

  assign advance    = !last.valid || Out_Ready;
  assign In_Ready   = advance;
  assign SHIFT_OUT  = last.data;
  assign SHIFT_Flag = last.valid;
  assign CARRY_OUT  = last.carry;
  assign MODE_ERR   = last.err;
  assign ZERO_Flag  = (last.data == '0);

  // Routing fields are spent by the time the beat reaches the output.
  logic unused_tail;
  assign unused_tail = ^{last.shamt, last.mode, last.sign};

endmodule

// File: tb/tb_barrel_shift_unit.sv
module tb_barrel_shift_unit;
  import shift_pkg::*;

  localparam int W  = 16;
  localparam int SW = 5;
  localparam int EW = W + 2;  // {data, carry, err}

  logic          CLK;
  logic          RST;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          SRC_SEL;
  logic [2:0]    SHIFT_MODE;
  logic [SW-1:0] SHAMT;
  logic          In_Valid;
  logic          In_Ready;
  logic [W-1:0]  SHIFT_OUT;
  logic          SHIFT_Flag;
  logic          Out_Ready;
  logic          CARRY_OUT;
  logic          ZERO_Flag;
  logic          MODE_ERR;

  barrel_shift_unit #(.WIDTH(W), .PIPE_STAGES(2)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .A          (A),
    .B          (B),
    .SRC_SEL    (SRC_SEL),
    .SHIFT_MODE (SHIFT_MODE),
    .SHAMT      (SHAMT),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .SHIFT_OUT  (SHIFT_OUT),
    .SHIFT_Flag (SHIFT_Flag),
    .Out_Ready  (Out_Ready),
    .CARRY_OUT  (CARRY_OUT),
    .ZERO_Flag  (ZERO_Flag),
    .MODE_ERR   (MODE_ERR)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: looks mid-cycle at a beat that will transfer on the next edge.
  always @(negedge CLK) begin
    logic [EW-1:0] e;
    #2;
    if (!RST && SHIFT_Flag && Out_Ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'(SHIFT_Flag), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_data",  32'(SHIFT_OUT), 32'(e[EW-1:2]));
        check("out_carry", 32'(CARRY_OUT), 32'(e[1]));
        check("out_err",   32'(MODE_ERR),  32'(e[0]));
        check("out_zero",  32'(ZERO_Flag), 32'(e[EW-1:2] == '0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic src, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] mode, input logic [SW-1:0] sh,
                      input logic [W-1:0] e_data, input logic e_carry, input logic e_err);
    int waited;
    @(negedge CLK);
    SRC_SEL    = src;
    A          = a;
    B          = b;
    SHIFT_MODE = mode;
    SHAMT      = sh;
    In_Valid   = 1'b1;
    exp_q.push_back({e_data, e_carry, e_err});
    #1;
    waited = 0;
    while (!In_Ready && waited < 50) begin
      @(negedge CLK);
      #1;
      waited++;
    end
    if (!In_Ready) check("accept_timeout", 32'(In_Ready), 32'd1);
  endtask

  task automatic go_idle();
    @(negedge CLK);
    In_Valid   = 1'b0;
    A          = 16'hDEAD;  // scribble: in-flight beats must not see this
    B          = 16'hBEEF;
    SHIFT_MODE = 3'(MODE_LSL);
    SHAMT      = 5'd3;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(negedge CLK);
      cyc++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic          src;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    mode;
    logic [SW-1:0] sh;
    logic [W-1:0]  d;
    logic          c;
    logic          e;
  } vec_t;

  vec_t vecs[$];
  vec_t bp[$];

  initial begin
    //            src  a         b         mode      sh     result    c     e
    vecs.push_back('{1'b1, 16'h1111, 16'h8000, MODE_ASR, 5'd20, 16'hFFFF, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 16'h00F0, 16'h5555, MODE_LSR, 5'd16, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0001, 16'h0000, MODE_ROR, 5'd17, 16'h8000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 16'h0001, 16'h0000, MODE_ROL, 5'd16, 16'h0001, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h1234, 16'h0000, 3'b110,   5'd5,  16'h1234, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 16'h1234, 16'h0000, MODE_LSR, 5'd4,  16'h0123, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h8000, 16'h0000, MODE_LSR, 5'd16, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 16'h0001, 16'h0000, MODE_LSL, 5'd16, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 16'h0001, 16'h0000, MODE_LSL, 5'd17, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h8000, 16'h0000, MODE_ASR, 5'd16, 16'hFFFF, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 16'h4000, 16'h0000, MODE_ASR, 5'd16, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'hF00F, 16'h0000, MODE_ASR, 5'd0,  16'hF00F, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h1234, 16'h0000, MODE_ROL, 5'd4,  16'h2341, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 16'h1234, 16'h0000, MODE_ROR, 5'd8,  16'h3412, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h1234, 16'h0000, MODE_ROR, 5'd31, 16'h2468, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 16'hAAAA, 16'h00FF, MODE_LSL, 5'd4,  16'h0FF0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h8421, 16'h0000, MODE_LSR, 5'd31, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0003, 16'h0000, MODE_LSR, 5'd1,  16'h0001, 1'b1, 1'b0});

    bp.push_back('{1'b0, 16'h0F0F, 16'h0000, MODE_LSL, 5'd4,  16'hF0F0, 1'b0, 1'b0});
    bp.push_back('{1'b0, 16'h8000, 16'h0000, MODE_ASR, 5'd3,  16'hF000, 1'b0, 1'b0});
    bp.push_back('{1'b0, 16'h0081, 16'h0000, MODE_ROR, 5'd1,  16'h8040, 1'b1, 1'b0});
    bp.push_back('{1'b0, 16'hFFFF, 16'h0000, MODE_LSR, 5'd15, 16'h0001, 1'b1, 1'b0});
    bp.push_back('{1'b0, 16'h1000, 16'h0000, MODE_LSL, 5'd4,  16'h0000, 1'b1, 1'b0});
  end

  // ---------------- main sequence ----------------
  initial begin
    int flag_cnt;
    RST        = 1'b1;
    A          = '0;
    B          = '0;
    SRC_SEL    = 1'b0;
    SHIFT_MODE = '0;
    SHAMT      = '0;
    In_Valid   = 1'b0;
    Out_Ready  = 1'b1;

    // Reset state
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    check("rst_flag",  32'(SHIFT_Flag), 32'd0);
    check("rst_out",   32'(SHIFT_OUT),  32'd0);
    check("rst_zero",  32'(ZERO_Flag),  32'd1);
    check("rst_ready", 32'(In_Ready),   32'd1);
    check("rst_carry", 32'(CARRY_OUT),  32'd0);
    check("rst_err",   32'(MODE_ERR),   32'd0);

    // First beat: latency of exactly two cycles
    send(1'b0, 16'h8001, 16'h0000, MODE_LSL, 5'd1, 16'h0002, 1'b1, 1'b0);
    go_idle();
    #1;
    check("lat_cycle1", 32'(SHIFT_Flag), 32'd0);
    @(negedge CLK);
    #1;
    check("lat_cycle2", 32'(SHIFT_Flag), 32'd1);
    drain();

    // Directed table, back to back
    foreach (vecs[i]) begin
      send(vecs[i].src, vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].sh,
           vecs[i].d, vecs[i].c, vecs[i].e);
    end
    go_idle();
    drain();

    // Backpressure: 5 beats, Out_Ready low for 4 cycles once the first result shows
    @(negedge CLK);
    fork
      begin
        foreach (bp[i]) begin
          send(bp[i].src, bp[i].a, bp[i].b, bp[i].mode, bp[i].sh,
               bp[i].d, bp[i].c, bp[i].e);
        end
        go_idle();
      end
      begin
        repeat (3) @(negedge CLK);
        Out_Ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (k > 0) @(negedge CLK);
          #3;
          check("bp_ready_low", 32'(In_Ready),   32'd0);
          check("bp_flag_hold", 32'(SHIFT_Flag), 32'd1);
          check("bp_data_hold", 32'(SHIFT_OUT),  32'(bp[0].d));
          check("bp_carry_hold", 32'(CARRY_OUT), 32'(bp[0].c));
        end
        @(negedge CLK);
        Out_Ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight
    @(negedge CLK);
    Out_Ready = 1'b0;
    send(1'b0, 16'h00AA, 16'h0000, MODE_LSL, 5'd1, 16'h0154, 1'b0, 1'b0);
    send(1'b0, 16'h00BB, 16'h0000, MODE_LSR, 5'd1, 16'h005D, 1'b1, 1'b0);
    @(negedge CLK);
    In_Valid = 1'b0;
    #1;
    check("pre_rst_flag", 32'(SHIFT_Flag), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("mid_rst_flag",  32'(SHIFT_Flag), 32'd0);
    check("mid_rst_out",   32'(SHIFT_OUT),  32'd0);
    check("mid_rst_zero",  32'(ZERO_Flag),  32'd1);
    check("mid_rst_ready", 32'(In_Ready),   32'd1);
    exp_q.delete();
    Out_Ready = 1'b1;
    flag_cnt = 0;
    repeat (6) begin
      @(negedge CLK);
      #1;
      if (SHIFT_Flag) flag_cnt++;
    end
    check("rst_discard", 32'(flag_cnt), 32'd0);

    // Pipeline still works after the mid-stream reset
    send(1'b0, 16'h0001, 16'h0000, MODE_ROL, 5'd1, 16'h0002, 1'b0, 1'b0);
    go_idle();
    drain();
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    n_errors++;
    $display("FAIL global_timeout got running expected finished");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
